// File: rtl/mlp_loss_stage_pkg.sv
// Shared types and constants for the output-side loss/training stage.
package mlp_loss_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EVAL,
    UPDATE
  } loss_state_e;

  // Next-layer weight seen by any layer that has no successor.
  localparam real UNIT_WEIGHT = 1.0;

endpackage

// File: rtl/mlp_loss_stage_if.sv
// Sample handshake plus gradient/epoch reporting bus of the loss stage.
interface mlp_loss_stage_if #(
  parameter int unsigned OUTPUT_UNITS = 2
);

  logic        sample_valid;
  logic        sample_ready;
  real         target             [OUTPUT_UNITS];
  real         prediction         [OUTPUT_UNITS];
  logic        train_enable;
  real         error_gradient_out [OUTPUT_UNITS];
  real         unit_weights       [OUTPUT_UNITS];
  logic        training;
  logic        epoch_done;
  real         epoch_loss;
  logic [31:0] epoch_count;

  modport master (
    output sample_valid, target, prediction, train_enable,
    input  sample_ready, error_gradient_out, unit_weights, training,
           epoch_done, epoch_loss, epoch_count
  );

  modport slave (
    input  sample_valid, target, prediction, train_enable,
    output sample_ready, error_gradient_out, unit_weights, training,
           epoch_done, epoch_loss, epoch_count
  );

endinterface

// File: rtl/mlp_loss_stage_loss_accumulator.sv
// Sums per-sample loss and publishes the mean at each epoch boundary.
module loss_accumulator #(
  parameter int unsigned SAMPLES_PER_EPOCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_add,
  input  real         i_sample_loss,
  output real         o_epoch_loss,
  output logic [31:0] o_epoch_count,
  output logic        o_epoch_done
);

  localparam int unsigned    CW   = $clog2(SAMPLES_PER_EPOCH + 1);
  localparam logic [CW-1:0]  LAST = CW'(SAMPLES_PER_EPOCH - 1);

  real           r_acc;
  logic [CW-1:0] r_count;
  real           r_epoch_loss;
  logic [31:0]   r_epoch_count;
  logic          r_epoch_done;
  logic          w_close;

  assign w_close = i_add && (r_count == LAST);

  // The closing sample is folded straight into the mean, never into r_acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc         <= 0.0;
      r_count       <= '0;
      r_epoch_loss  <= 0.0;
      r_epoch_count <= '0;
      r_epoch_done  <= 1'b0;
    end else begin
      r_epoch_done <= w_close;
      if (w_close) begin
        r_epoch_loss  <= (r_acc + i_sample_loss) / real'(SAMPLES_PER_EPOCH);
        r_acc         <= 0.0;
        r_count       <= '0;
        r_epoch_count <= r_epoch_count + 32'd1;
      end else if (i_add) begin
        r_acc   <= r_acc + i_sample_loss;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_epoch_loss  = r_epoch_loss;
  assign o_epoch_count = r_epoch_count;
  assign o_epoch_done  = r_epoch_done;

endmodule

// File: rtl/mlp_loss_stage.sv
// Output-side training controller: captures a labelled sample, waits for the
// network to settle, feeds back (prediction - target) and strobes training.
module mlp_loss_stage
  import mlp_loss_stage_pkg::*;
#(
  parameter int unsigned OUTPUT_UNITS      = 2,
  parameter int unsigned SAMPLES_PER_EPOCH = 4,
  parameter int unsigned SETTLE_CYCLES     = 2
) (
  input logic             clk,
  input logic             rst,
  mlp_loss_stage_if.slave bus
);

  localparam int unsigned    SCW         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  loss_state_e    r_state;
  loss_state_e    w_next_state;
  logic [SCW-1:0] r_settle_cnt;
  logic           r_train_q;
  real            r_target_q [OUTPUT_UNITS];
  real            r_grad     [OUTPUT_UNITS];
  real            w_diff     [OUTPUT_UNITS];
  real            w_sum_sq;
  real            w_sample_loss;
  logic           w_ready;
  logic           w_accept;
  logic           w_training;
  logic           w_add;
  real            w_epoch_loss;
  logic [31:0]    w_epoch_count;
  logic           w_epoch_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = SETTLE;
      SETTLE:  if (r_settle_cnt == SETTLE_LAST) w_next_state = EVAL;
      EVAL:    w_next_state = r_train_q ? UPDATE : IDLE;
      UPDATE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Gated by rst so an interrupted sample never strobes or accumulates.
  always_comb begin
    w_ready    = 1'b0;
    w_training = 1'b0;
    w_add      = 1'b0;
    unique case (r_state)
      IDLE:    w_ready    = !rst;
      EVAL:    w_add      = !rst;
      UPDATE:  w_training = !rst;
      default: ;
    endcase
  end

  assign w_accept = bus.sample_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst || (r_state != SETTLE)) r_settle_cnt <= '0;
    else                            r_settle_cnt <= r_settle_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_train_q <= 1'b0;
      for (int unsigned i = 0; i < OUTPUT_UNITS; i++) r_target_q[i] <= 0.0;
    end else if (w_accept) begin
      r_train_q <= bus.train_enable;
      for (int unsigned i = 0; i < OUTPUT_UNITS; i++) r_target_q[i] <= bus.target[i];
    end
  end

  always_comb begin
    w_sum_sq = 0.0;
    for (int unsigned i = 0; i < OUTPUT_UNITS; i++) begin
      w_diff[i] = bus.prediction[i] - r_target_q[i];
      w_sum_sq  = w_sum_sq + w_diff[i] * w_diff[i];
    end
    w_sample_loss = 0.5 * w_sum_sq;
  end

  // Loaded in EVAL, held through UPDATE, cleared otherwise.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < OUTPUT_UNITS; i++) begin
      if (rst)                      r_grad[i] <= 0.0;
      else if (r_state == EVAL)     r_grad[i] <= w_diff[i];
      else if (r_state != UPDATE)   r_grad[i] <= 0.0;
    end
  end

  loss_accumulator #(
    .SAMPLES_PER_EPOCH (SAMPLES_PER_EPOCH)
  ) u_acc (
    .clk           (clk),
    .rst           (rst),
    .i_add         (w_add),
    .i_sample_loss (w_sample_loss),
    .o_epoch_loss  (w_epoch_loss),
    .o_epoch_count (w_epoch_count),
    .o_epoch_done  (w_epoch_done)
  );

  assign bus.sample_ready = w_ready;
  assign bus.training     = w_training;
  assign bus.epoch_loss   = w_epoch_loss;
  assign bus.epoch_count  = w_epoch_count;
  assign bus.epoch_done   = w_epoch_done;

  for (genvar g = 0; g < OUTPUT_UNITS; g++) begin : g_out
    assign bus.error_gradient_out[g] = r_grad[g];
    assign bus.unit_weights[g]       = UNIT_WEIGHT;
  end

endmodule

// File: tb/tb_mlp_loss_stage.sv
// Scoreboard bench for mlp_loss_stage: randomized samples against an
// arithmetic reference model, with a decoupled output monitor.
module tb_mlp_loss_stage;

  localparam int NU  = 2;
  localparam int SPE = 4;
  localparam int SC  = 2;

  typedef struct {
    real g0;
    real g1;
    int  cyc;
  } grad_t;

  typedef struct {
    real         loss;
    logic [31:0] cnt;
    int          cyc;
  } epoch_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  grad_t  gq[$];
  epoch_t eq[$];
  grad_t  mon_g;
  epoch_t mon_e;

  real         m_sum = 0.0;
  int          m_n   = 0;
  logic [31:0] m_cnt = '0;

  mlp_loss_stage_if #(.OUTPUT_UNITS(NU)) bus ();

  mlp_loss_stage #(
    .OUTPUT_UNITS      (NU),
    .SAMPLES_PER_EPOCH (SPE),
    .SETTLE_CYCLES     (SC)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_r(input string nm, input real act, input real exp);
    n_vec++;
    if ((act - exp > 1.0e-9) || (exp - act > 1.0e-9)) begin
      n_miss++;
      $display("FAIL %s: got %f expected %f (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_i(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic real rnd();
    return real'($urandom_range(0, 4095)) / 1024.0 - 2.0;
  endfunction

  // Monitor: pops an expectation whenever the DUT strobes training or epoch_done.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.training) begin
        chk_i("training_expected", longint'(gq.size() > 0), 1);
        if (gq.size() > 0) begin
          mon_g = gq.pop_front();
          chk_i("training_cycle", cyc, mon_g.cyc);
          chk_r("grad0", bus.error_gradient_out[0], mon_g.g0);
          chk_r("grad1", bus.error_gradient_out[1], mon_g.g1);
        end
      end
      if (bus.epoch_done) begin
        chk_i("epoch_done_expected", longint'(eq.size() > 0), 1);
        if (eq.size() > 0) begin
          mon_e = eq.pop_front();
          chk_i("epoch_done_cycle", cyc, mon_e.cyc);
          chk_r("epoch_loss", bus.epoch_loss, mon_e.loss);
          chk_i("epoch_count", bus.epoch_count, mon_e.cnt);
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge with the DUT ready again.
  task automatic send(input real t0, input real t1, input real p0, input real p1,
                      input bit trn, input bit glitch);
    int    k;
    int    c0;
    real   d0;
    real   d1;
    real   l;
    grad_t g;
    epoch_t e;
    k = 0;
    while (!bus.sample_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk_i("ready_before_send", bus.sample_ready, 1);
    bus.sample_valid  = 1'b1;
    bus.target[0]     = t0;
    bus.target[1]     = t1;
    bus.prediction[0] = p0;
    bus.prediction[1] = p1;
    bus.train_enable  = trn;
    c0 = cyc;
    d0 = p0 - t0;
    d1 = p1 - t1;
    l  = 0.5 * (d0 * d0 + d1 * d1);
    if (trn) begin
      g.g0 = d0; g.g1 = d1; g.cyc = c0 + SC + 2;
      gq.push_back(g);
    end
    m_sum = m_sum + l;
    m_n++;
    if (m_n == SPE) begin
      m_cnt = m_cnt + 32'd1;
      e.loss = m_sum / SPE; e.cnt = m_cnt; e.cyc = c0 + SC + 2;
      eq.push_back(e);
      m_sum = 0.0;
      m_n   = 0;
    end
    @(negedge clk);
    if (!glitch) bus.sample_valid = 1'b0;
    k = 0;
    while (!bus.sample_ready && k < 100) begin
      if (glitch) begin
        bus.target[0] = rnd();
        bus.target[1] = rnd();
      end
      @(negedge clk);
      k++;
    end
    chk_i("ready_return_cycle", cyc, c0 + SC + (trn ? 3 : 2));
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by time limit, got %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_valid  = 1'b0;
    bus.train_enable  = 1'b0;
    bus.target[0]     = 0.0;
    bus.target[1]     = 0.0;
    bus.prediction[0] = 0.0;
    bus.prediction[1] = 0.0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("ready_in_reset", bus.sample_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_i("ready_after_reset", bus.sample_ready, 1);
    chk_i("training_reset", bus.training, 0);
    chk_i("epoch_done_reset", bus.epoch_done, 0);
    chk_i("epoch_count_reset", bus.epoch_count, 0);
    chk_r("epoch_loss_reset", bus.epoch_loss, 0.0);
    chk_r("grad0_reset", bus.error_gradient_out[0], 0.0);
    chk_r("grad1_reset", bus.error_gradient_out[1], 0.0);
    chk_r("unit_weight0", bus.unit_weights[0], 1.0);
    chk_r("unit_weight1", bus.unit_weights[1], 1.0);

    // Evaluate-only sample; loss goes into the accumulator.
    send(1.0, 0.0, 0.75, 0.25, 1'b0, 1'b0);

    // Reset in the middle of SETTLE abandons a trained sample.
    bus.sample_valid = 1'b1;
    bus.train_enable = 1'b1;
    bus.target[0]    = 0.5;
    bus.target[1]    = -0.5;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_i("ready_mid_reset", bus.sample_ready, 0);
      chk_i("training_mid_reset", bus.training, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_i("ready_after_abort", bus.sample_ready, 1);
    chk_r("grad0_after_abort", bus.error_gradient_out[0], 0.0);
    chk_i("epoch_count_after_abort", bus.epoch_count, 0);
    chk_r("epoch_loss_after_abort", bus.epoch_loss, 0.0);
    m_sum = 0.0;
    m_n   = 0;
    repeat (6) @(negedge clk);

    // One epoch of fixed samples, each loss 0.0625; third one glitches target.
    send(1.0, 0.0, 0.75, 0.25, 1'b1, 1'b0);
    send(1.0, 0.0, 0.75, 0.25, 1'b1, 1'b0);
    send(1.0, 0.0, 0.75, 0.25, 1'b1, 1'b1);
    send(1.0, 0.0, 0.75, 0.25, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      send(rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Counter wrap at the next epoch close.
    force u_dut.u_acc.r_epoch_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_dut.u_acc.r_epoch_count;
    m_cnt = 32'hFFFF_FFFF;
    do begin
      send(rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
    end while (m_n != 0);

    repeat (10) @(negedge clk);
    chk_i("grad_queue_drained", gq.size(), 0);
    chk_i("epoch_queue_drained", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
